// File: rtl/ram_rw_ctrl.sv
// RAM bring-up access generator: writes a pattern to every word, reads it back and counts mismatches.
// Optional macro RAM_RW_AUTO_START_EN: back-to-back self-started passes with alternating pattern polarity.
module ram_rw_ctrl #(
  parameter int               DEPTH      = 32,
  parameter int               ADDR_W     = 5,
  parameter int               DATA_W     = 8,
  parameter logic [DATA_W-1:0] DATA_PAT  = 8'h00,
  parameter int               RD_LATENCY = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_cnt,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LATENCY - 1);

  // Address placed into the data lane: zero-extended or truncated to DATA_W.
  function automatic logic [DATA_W-1:0] fit(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < ADDR_W && i < DATA_W; i++) v[i] = a[i];
    return v;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [1:0]        r_lat_cnt, w_lat_cnt_nxt;
  logic              w_en_nxt, w_we_nxt, w_busy_nxt, w_done_nxt;
  logic [DATA_W-1:0] w_wr_data_nxt;
  logic              w_go;
  logic              w_pass_start;
  logic [DATA_W-1:0] w_cur_pat;
  logic [DATA_W-1:0] w_start_pat;

`ifdef RAM_RW_AUTO_START_EN
  logic              w_unused_start;
  logic [DATA_W-1:0] r_pat;

  assign w_unused_start = start;
  assign w_go           = 1'b1;
  assign w_cur_pat      = r_pat;
  assign w_start_pat    = ~r_pat;

  // Reset value is the inverse so the first pass flips it back to DATA_PAT.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)        r_pat <= ~DATA_PAT;
    else if (w_pass_start) r_pat <= ~r_pat;
  end
`else
  assign w_go        = start;
  assign w_cur_pat   = DATA_PAT;
  assign w_start_pat = DATA_PAT;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_lat_cnt_nxt = r_lat_cnt;
    w_en_nxt      = 1'b0;
    w_we_nxt      = 1'b0;
    w_wr_data_nxt = '0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_pass_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt   = S_WRITE;
          w_pass_start  = 1'b1;
          w_addr_nxt    = '0;
          w_en_nxt      = 1'b1;
          w_we_nxt      = 1'b1;
          w_wr_data_nxt = fit('0) ^ w_start_pat;
          w_busy_nxt    = 1'b1;
        end
      end
      S_WRITE: begin
        w_en_nxt   = 1'b1;
        w_busy_nxt = 1'b1;
        if (r_addr == ADDR_LAST) begin
          w_state_nxt = S_READ;
          w_addr_nxt  = '0;
        end else begin
          w_addr_nxt    = r_addr + 1'b1;
          w_we_nxt      = 1'b1;
          w_wr_data_nxt = fit(r_addr + 1'b1) ^ w_cur_pat;
        end
      end
      S_READ: begin
        w_busy_nxt = 1'b1;
        if (r_addr == ADDR_LAST) begin
          w_state_nxt   = S_DRAIN;
          w_addr_nxt    = '0;
          w_lat_cnt_nxt = '0;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
          w_en_nxt   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_lat_cnt   <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      ram_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
      ram_en      <= w_en_nxt;
      ram_we      <= w_we_nxt;
      ram_wr_data <= w_wr_data_nxt;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
    end
  end

  assign ram_addr  = r_addr;
  assign dbg_state = r_state;

  // Expected word travels alongside the read so it meets ram_rd_data RD_LATENCY cycles later.
  logic              r_pipe_vld [RD_LATENCY];
  logic [DATA_W-1:0] r_pipe_exp [RD_LATENCY];
  logic              w_mismatch;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_exp[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= ram_en & ~ram_we;
      r_pipe_exp[0] <= fit(r_addr) ^ w_cur_pat;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_exp[i] <= r_pipe_exp[i-1];
      end
    end
  end

  assign w_mismatch = r_pipe_vld[RD_LATENCY-1] && (ram_rd_data != r_pipe_exp[RD_LATENCY-1]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (w_pass_start) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (w_mismatch) begin
      err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_rw_ctrl.sv
// Bench for ram_rw_ctrl: behavioural latency-1 RAM, access/done scoreboard, directed reset and start scenarios.
// With RAM_RW_AUTO_START_EN defined it exercises the self-started back-to-back passes instead.
module tb_ram_rw_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       start;
  logic       ram_en, ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_wr_data;
  logic [7:0] ram_rd_data;
  logic       busy, done, err;
  logic [4:0] err_cnt;
  logic [2:0] dbg_state;

  ram_rw_ctrl #(
    .DEPTH(32), .ADDR_W(5), .DATA_W(8), .DATA_PAT(8'h00), .RD_LATENCY(1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .start      (start),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // behavioural RAM; ram_fault corrupts reads of address 5
  logic [7:0] mem [32];
  logic       ram_fault;
  always @(posedge sys_clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wr_data;
      else        ram_rd_data <= (ram_fault && ram_addr == 5'd5) ? 8'hFF : mem[ram_addr];
    end
  end

  // scoreboard
  logic [13:0] exp_q[$];
  logic [5:0]  done_q[$];
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (ram_en) begin
        if (exp_q.size() == 0) check("unexpected_access", {ram_we, ram_addr, ram_wr_data}, 32'hFFFF_FFFF);
        else check("ram_access", {ram_we, ram_addr, ram_wr_data}, exp_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", {err, err_cnt}, 32'hFFFF_FFFF);
        else check("done_err", {err, err_cnt}, done_q.pop_front());
        check("busy_cycles", busy_cnt, 65);
        check("busy_at_done", busy, 0);
        busy_cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic push_pass(input logic [7:0] pat, input logic [5:0] exp_done);
    for (int a = 0; a < 32; a++) exp_q.push_back({1'b1, 5'(a), 8'(a) ^ pat});
    for (int a = 0; a < 32; a++) exp_q.push_back({1'b0, 5'(a), 8'h00});
    done_q.push_back(exp_done);
  endtask

  task automatic flush();
    exp_q.delete();
    done_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge sys_clk);
      cyc++;
    end while (!done && cyc < 300);
    check("done_seen", done, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en"}, ram_en, 0);
    check({tag, "_we"}, ram_we, 0);
    check({tag, "_addr"}, ram_addr, 0);
    check({tag, "_wdata"}, ram_wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_errcnt"}, err_cnt, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    int c1, c2, n;
    sys_rst_n = 1'b0;
    start     = 1'b0;
    ram_fault = 1'b0;
    #200;
    check_zero("reset");
    sys_rst_n = 1'b1;

`ifdef RAM_RW_AUTO_START_EN
    push_pass(8'h00, 6'h00);
    push_pass(8'hFF, 6'h00);
    wait_done(c1);
    wait_done(c2);
    check("done_spacing", c2, 67);
    #1 sys_rst_n = 1'b0;
    flush();
    #1 check_zero("auto_reset");
`else
    // clean pass
    push_pass(8'h00, 6'h00);
    pulse_start();
    wait_done(c1);

    // asynchronous reset while reading
    push_pass(8'h00, 6'h00);
    pulse_start();
    n = 0;
    while (!(ram_en && !ram_we) && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("reached_read", ram_en && !ram_we, 1);
    #5 sys_rst_n = 1'b0;
    flush();
    #1 check_zero("reset_read");
    #194 sys_rst_n = 1'b1;

    // corrupted word at address 5, then sticky flag and clear on the next start
    ram_fault = 1'b1;
    push_pass(8'h00, {1'b1, 5'd1});
    pulse_start();
    wait_done(c1);
    repeat (3) @(negedge sys_clk);
    check("err_sticky", err, 1);
    check("errcnt_sticky", err_cnt, 1);
    ram_fault = 1'b0;
    push_pass(8'h00, 6'h00);
    pulse_start();
    check("err_clear", err, 0);
    check("errcnt_clear", err_cnt, 0);
    wait_done(c1);

    // start during WRITE and during DONE is ignored
    push_pass(8'h00, 6'h00);
    pulse_start();
    repeat (5) @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    wait_done(c1);
    start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    repeat (80) @(negedge sys_clk);
    check("no_requeue_busy", busy, 0);

    // reset in the middle of WRITE, then a fresh pass restarts at address 0
    push_pass(8'h00, 6'h00);
    pulse_start();
    n = 0;
    while (!(ram_en && ram_we && ram_addr == 5'd10) && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("reached_addr10", ram_addr, 10);
    #1 sys_rst_n = 1'b0;
    flush();
    #199 sys_rst_n = 1'b1;
    push_pass(8'h00, 6'h00);
    pulse_start();
    wait_done(c1);
`endif

    repeat (3) @(negedge sys_clk);
    check("acc_queue_empty", exp_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
